// File: rtl/pipe_stage_reg_if.sv
// Bundle of the upstream and downstream handshake/payload signals of one
// pipeline stage boundary. The stage itself uses the slave view; whatever
// feeds and drains the stage uses the master view.
interface pipe_stage_reg_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int EXC_W   = 9
) ();

   // Upstream side
   logic               in_valid;
   logic               in_ready;
   logic               in_ctrl;
   logic [PC_W-1:0]    in_pc;
   logic [INSTR_W-1:0] in_instr;
   logic [EXC_W-1:0]   in_exc;

   // Downstream side
   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_pc;
   logic [INSTR_W-1:0] out_instr;
   logic [EXC_W-1:0]   out_exc;
   logic               out_bds;

   modport master (
      output in_valid, in_ctrl, in_pc, in_instr, in_exc, out_ready,
      input  in_ready, out_valid, out_pc, out_instr, out_exc, out_bds
   );

   modport slave (
      input  in_valid, in_ctrl, in_pc, in_instr, in_exc, out_ready,
      output in_ready, out_valid, out_pc, out_instr, out_exc, out_bds
   );

endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (IF/ID, ID/EX, ...) carrying PC, instruction
// and exception bits, tagging branch-delay-slot entries. With SKID=1 a second
// entry absorbs one beat of backpressure so in_ready comes from a flop; with
// SKID=0 the stage is a single entry with combinational in_ready.
//
// Handshake: a beat moves on a rising edge where valid and ready are both
// high. valid never depends on ready; while valid is high and ready is low the
// payload is held unchanged. flush overrides every handshake event.
module pipe_stage_reg #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int EXC_W   = 9,
   parameter int SKID    = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   pipe_stage_reg_if.slave  bus,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'd0,
      ST_FULL     = 2'd1,
      ST_SKIDFULL = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_in_ready;

   logic [PC_W-1:0]    r_main_pc;
   logic [INSTR_W-1:0] r_main_instr;
   logic [EXC_W-1:0]   r_main_exc;
   logic               r_main_bds;

   logic [PC_W-1:0]    r_skid_pc;
   logic [INSTR_W-1:0] r_skid_instr;
   logic [EXC_W-1:0]   r_skid_exc;
   logic               r_skid_bds;

   logic               r_prev_ctrl;
   logic [CNT_W-1:0]   r_stall_cnt;

   logic               w_out_valid;
   logic               w_in_ready;
   logic               w_push;
   logic               w_pop;
   logic               w_ld_main_in;
   logic               w_ld_main_skid;
   logic               w_ld_skid;

   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || bus.out_ready);
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready;

   // Next state and which register loads from where on this edge
   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_push) begin
                  w_state_nxt  = ST_FULL;
                  w_ld_main_in = 1'b1;
               end
            end
            ST_FULL: begin
               if (w_push) begin
                  // Without a skid slot a push into FULL only happens with a pop
                  if (w_pop || (SKID == 0)) begin
                     w_ld_main_in = 1'b1;
                  end else begin
                     w_state_nxt = ST_SKIDFULL;
                     w_ld_skid   = 1'b1;
                  end
               end else if (w_pop) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_SKIDFULL: begin
               if (w_pop) begin
                  w_state_nxt    = ST_FULL;
                  w_ld_main_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   // State register; in_ready is registered off the next state so it has no path from out_ready
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_SKIDFULL);
      end
   end

   // Payload registers and BDS tracking; flush leaves a zero (NOP) bubble
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_main_pc    <= '0;
         r_main_instr <= '0;
         r_main_exc   <= '0;
         r_main_bds   <= 1'b0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_skid_exc   <= '0;
         r_skid_bds   <= 1'b0;
         r_prev_ctrl  <= 1'b0;
      end else if (flush) begin
         r_main_pc    <= '0;
         r_main_instr <= '0;
         r_main_exc   <= '0;
         r_main_bds   <= 1'b0;
         r_skid_pc    <= '0;
         r_skid_instr <= '0;
         r_skid_exc   <= '0;
         r_skid_bds   <= 1'b0;
         r_prev_ctrl  <= 1'b0;
      end else begin
         if (w_ld_main_in) begin
            r_main_pc    <= bus.in_pc;
            r_main_instr <= bus.in_instr;
            r_main_exc   <= bus.in_exc;
            r_main_bds   <= r_prev_ctrl;
         end else if (w_ld_main_skid) begin
            r_main_pc    <= r_skid_pc;
            r_main_instr <= r_skid_instr;
            r_main_exc   <= r_skid_exc;
            r_main_bds   <= r_skid_bds;
         end
         if (w_ld_skid) begin
            r_skid_pc    <= bus.in_pc;
            r_skid_instr <= bus.in_instr;
            r_skid_exc   <= bus.in_exc;
            r_skid_bds   <= r_prev_ctrl;
         end
         if (w_push) begin
            r_prev_ctrl <= bus.in_ctrl;
         end
      end
   end

   // Saturating count of cycles the output is held by downstream; flush does not clear it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_pc    = r_main_pc;
   assign bus.out_instr = r_main_instr;
   assign bus.out_exc   = r_main_exc;
   assign bus.out_bds   = r_main_bds;
   assign stall_cnt     = r_stall_cnt;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/CNT_W=4 stage and a SKID=0/CNT_W=16
// stage see identical stimulus, each compared every cycle against its own
// queue-based reference model, plus fixed-value checks for the directed cases.
module tb_pipe_stage_reg;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        d_flush;
   logic [3:0]  cnt_a;
   logic [15:0] cnt_b;
   logic [1:0]  dbg_a;
   logic [1:0]  dbg_b;

   pipe_stage_reg_if #(.PC_W(32), .INSTR_W(32), .EXC_W(9)) u_if_a ();
   pipe_stage_reg_if #(.PC_W(32), .INSTR_W(32), .EXC_W(9)) u_if_b ();

   pipe_stage_reg #(.PC_W(32), .INSTR_W(32), .EXC_W(9), .SKID(1), .CNT_W(4)) u_dut_a (
      .clk         (clk),
      .reset       (rst),
      .flush       (d_flush),
      .bus         (u_if_a),
      .stall_cnt   (cnt_a),
      .o_dbg_state (dbg_a)
   );

   pipe_stage_reg #(.PC_W(32), .INSTR_W(32), .EXC_W(9), .SKID(0), .CNT_W(16)) u_dut_b (
      .clk         (clk),
      .reset       (rst),
      .flush       (d_flush),
      .bus         (u_if_b),
      .stall_cnt   (cnt_b),
      .o_dbg_state (dbg_b)
   );

   // ---------------- scoreboard state ----------------
   int          n_vec;
   int          n_err;
   logic        d_valid;
   logic        d_ctrl;
   logic        d_ordy;
   logic [31:0] d_pc;
   logic [31:0] d_instr;
   logic [8:0]  d_exc;

   // entry = {bds, exc[8:0], instr[31:0], pc[31:0]}
   logic [73:0]  exp_q [2][$];
   logic [73:0]  last_e [2];
   logic         prev_c [2];
   int unsigned  cnt_m [2];
   logic         rdy_m [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned cmax(input int k);
      return (k == 0) ? 32'd15 : 32'd65535;
   endfunction

   function automatic logic model_ready(input int k);
      if (k == 0) return (exp_q[0].size() < 2);
      return (exp_q[1].size() == 0) || d_ordy;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         exp_q[k].delete();
         last_e[k] = '0;
         prev_c[k] = 1'b0;
         cnt_m[k]  = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 2; k++) begin
         logic vld;
         logic psh;
         logic pp;
         vld = (exp_q[k].size() != 0);
         psh = d_valid && rdy_m[k];
         pp  = vld && d_ordy;
         if (vld && !d_ordy && (cnt_m[k] < cmax(k))) cnt_m[k]++;
         if (d_flush) begin
            exp_q[k].delete();
            last_e[k] = '0;
            prev_c[k] = 1'b0;
         end else begin
            if (pp) last_e[k] = exp_q[k].pop_front();
            if (psh) begin
               exp_q[k].push_back({prev_c[k], d_exc, d_instr, d_pc});
               prev_c[k] = d_ctrl;
            end
         end
      end
   endtask

   task automatic check_outputs();
      for (int k = 0; k < 2; k++) begin
         logic [73:0] e;
         logic        ov;
         logic        ob;
         logic [31:0] opc;
         logic [31:0] oin;
         logic [31:0] oc;
         logic [8:0]  oe;
         logic [1:0]  od;
         string       p;
         e = (exp_q[k].size() != 0) ? exp_q[k][0] : last_e[k];
         if (k == 0) begin
            p = "a"; ov = u_if_a.out_valid; opc = u_if_a.out_pc; oin = u_if_a.out_instr;
            oe = u_if_a.out_exc; ob = u_if_a.out_bds; oc = 32'(cnt_a); od = dbg_a;
         end else begin
            p = "b"; ov = u_if_b.out_valid; opc = u_if_b.out_pc; oin = u_if_b.out_instr;
            oe = u_if_b.out_exc; ob = u_if_b.out_bds; oc = 32'(cnt_b); od = dbg_b;
         end
         check({p, "_out_valid"}, 32'(ov), 32'(exp_q[k].size() != 0));
         check({p, "_out_pc"},    opc, e[31:0]);
         check({p, "_out_instr"}, oin, e[63:32]);
         check({p, "_out_exc"},   32'(oe), 32'(e[72:64]));
         check({p, "_out_bds"},   32'(ob), 32'(e[73]));
         check({p, "_stall_cnt"}, oc, cnt_m[k]);
         check({p, "_occupied"},  32'(od != 2'd0), 32'(exp_q[k].size() != 0));
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, c, input logic [31:0] pc, ins, input logic [8:0] ex,
                        input logic ordy, fl);
      d_valid = v; d_ctrl = c; d_pc = pc; d_instr = ins; d_exc = ex; d_ordy = ordy; d_flush = fl;
      u_if_a.in_valid = v;  u_if_b.in_valid = v;
      u_if_a.in_ctrl  = c;  u_if_b.in_ctrl  = c;
      u_if_a.in_pc    = pc; u_if_b.in_pc    = pc;
      u_if_a.in_instr = ins; u_if_b.in_instr = ins;
      u_if_a.in_exc   = ex; u_if_b.in_exc   = ex;
      u_if_a.out_ready = ordy; u_if_b.out_ready = ordy;
   endtask

   // Called at a falling edge: check state, apply inputs, run one rising edge.
   task automatic step(input logic v, c, input logic [31:0] pc, ins, input logic [8:0] ex,
                       input logic ordy, fl);
      check_outputs();
      drive(v, c, pc, ins, ex, ordy, fl);
      #1;
      rdy_m[0] = model_ready(0);
      rdy_m[1] = model_ready(1);
      check("a_in_ready", 32'(u_if_a.in_ready), 32'(rdy_m[0]));
      check("b_in_ready", 32'(u_if_b.in_ready), 32'(rdy_m[1]));
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] pc, input logic c, ordy);
      step(1'b1, c, pc, ~pc, pc[8:0], ordy, 1'b0);
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b0, d_pc, d_instr, d_exc, ordy, 1'b0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "simulation did not finish");
   end

   // ---------------- stimulus ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0, 9'h0, 1'b0, 1'b0);
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_a_valid", 32'(u_if_a.out_valid), 32'h0);
      check("rst_a_pc",    u_if_a.out_pc, 32'h0);
      check("rst_a_stall", 32'(cnt_a), 32'h0);
      check("rst_b_valid", 32'(u_if_b.out_valid), 32'h0);
      rst = 1'b0;

      // Streaming with out_ready=1
      push(32'h100, 1'b0, 1'b1);
      check("strm_valid0", 32'(u_if_a.out_valid), 32'h1);
      check("strm_pc0", u_if_a.out_pc, 32'h100);
      push(32'h104, 1'b0, 1'b1);
      check("strm_pc1", u_if_a.out_pc, 32'h104);
      push(32'h108, 1'b0, 1'b1);
      check("strm_pc2", u_if_a.out_pc, 32'h108);
      idle(1'b1);
      check("strm_stall", 32'(cnt_a), 32'h0);
      idle(1'b1);

      // Backpressure into the skid slot
      push(32'h200, 1'b0, 1'b0);
      push(32'h204, 1'b0, 1'b0);
      check("bp_in_ready", 32'(u_if_a.in_ready), 32'h0);
      check("bp_pc_held", u_if_a.out_pc, 32'h200);
      idle(1'b0);
      check("bp_pc_held2", u_if_a.out_pc, 32'h200);
      idle(1'b1);
      check("bp_pc_next", u_if_a.out_pc, 32'h204);
      check("bp_stall", 32'(cnt_a), 32'h2);
      idle(1'b1);

      // Branch-delay-slot tagging
      push(32'h300, 1'b1, 1'b1);
      check("bds_0", 32'(u_if_a.out_bds), 32'h0);
      push(32'h304, 1'b0, 1'b1);
      check("bds_1", 32'(u_if_a.out_bds), 32'h1);
      push(32'h308, 1'b0, 1'b1);
      check("bds_2", 32'(u_if_a.out_bds), 32'h0);
      idle(1'b1);

      // Flush while SKIDFULL with a concurrent push
      push(32'h400, 1'b0, 1'b0);
      push(32'h402, 1'b1, 1'b0);
      check("fl_pre_ready", 32'(u_if_a.in_ready), 32'h0);
      step(1'b1, 1'b1, 32'h404, ~32'h404, 9'h004, 1'b0, 1'b1);
      check("fl_valid", 32'(u_if_a.out_valid), 32'h0);
      check("fl_pc", u_if_a.out_pc, 32'h0);
      check("fl_instr", u_if_a.out_instr, 32'h0);
      check("fl_in_ready", 32'(u_if_a.in_ready), 32'h1);
      push(32'h500, 1'b0, 1'b1);
      check("fl_after_pc", u_if_a.out_pc, 32'h500);
      check("fl_after_bds", 32'(u_if_a.out_bds), 32'h0);
      idle(1'b1);
      check("fl_alone", 32'(u_if_a.out_valid), 32'h0);

      // Stall counter saturation (4-bit counter on stage a)
      push(32'h700, 1'b0, 1'b0);
      repeat (20) idle(1'b0);
      check("sat_stall", 32'(cnt_a), 32'hF);
      idle(1'b1);

      // Asynchronous reset in the middle of a cycle
      push(32'h600, 1'b1, 1'b0);
      check("ar_b_pre", u_if_b.out_pc, 32'h600);
      #2;
      rst = 1'b1;
      #1;
      check("ar_a_valid", 32'(u_if_a.out_valid), 32'h0);
      check("ar_b_valid", 32'(u_if_b.out_valid), 32'h0);
      check("ar_b_pc", u_if_b.out_pc, 32'h0);
      check("ar_a_stall", 32'(cnt_a), 32'h0);
      model_reset();
      drive(1'b0, 1'b0, 32'h0, 32'h0, 9'h0, 1'b1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      push(32'h604, 1'b0, 1'b1);
      check("ar_b_pc_after", u_if_b.out_pc, 32'h604);
      check("ar_b_bds_after", 32'(u_if_b.out_bds), 32'h0);
      idle(1'b1);

      // Randomized traffic with occasional flushes
      repeat (400) begin
         logic [31:0] r;
         r = $urandom;
         step(r[0], r[1], $urandom, $urandom, r[12:4], (r[3:2] != 2'b00), (r[20:16] == 5'd0));
      end
      idle(1'b1);
      check_outputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
